// File: rtl/dbus_arbiter.sv
// Two-master arbiter for the shared data-RAM port: m0 (MEM load/store) and
// m1 (fetch). m0 has priority, with a starvation limit that lets m1 through.
module dbus_arbiter #(
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t      state, state_nx;
  logic        owner;
  logic [3:0]  starve_cnt;
  logic [7:0]  tmo_cnt;
  logic        grant, grant_m1, tmo_hit, done_ok, done_err, drop, pulse;

  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYC - 1));
  // A master still sees its req high during its ack/err cycle; no grant then,
  // so a finished request is never issued twice.
  assign pulse   = m0_ack_o | m0_err_o | m1_ack_o | m1_err_o;

  assign stallreq_o = (m0_req_i & ~m0_ack_o & ~m0_err_o) |
                      (m1_req_i & ~m1_ack_o & ~m1_err_o);

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_m1 = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: if (!flush_i && !pulse && (m0_req_i || m1_req_i)) begin
        grant    = 1'b1;
        grant_m1 = m1_req_i & (~m0_req_i | (starve_cnt == 4'(STARVE_MAX)));
        state_nx = BUSY;
      end
      BUSY: begin
        if (s_ack_i) begin
          drop     = 1'b1;
          done_ok  = ~flush_i;
          state_nx = IDLE;
        end else if (tmo_hit) begin
          drop     = 1'b1;
          done_err = ~flush_i;
          state_nx = IDLE;
        end else if (flush_i) begin
          state_nx = DRAIN;
        end
      end
      // The slave cycle must run to completion; its result is discarded.
      DRAIN: if (s_ack_i || tmo_hit) begin
        drop     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      s_cyc_o    <= 1'b0;
      s_stb_o    <= 1'b0;
      s_we_o     <= 1'b0;
      s_addr_o   <= '0;
      s_data_o   <= '0;
      s_sel_o    <= '0;
      m0_data_o  <= '0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m1_data_o  <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
    end else begin
      state    <= state_nx;
      m0_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m1_err_o <= 1'b0;
      if (grant) begin
        owner    <= grant_m1;
        s_cyc_o  <= 1'b1;
        s_stb_o  <= 1'b1;
        s_we_o   <= grant_m1 ? m1_we_i   : m0_we_i;
        s_addr_o <= grant_m1 ? m1_addr_i : m0_addr_i;
        s_data_o <= grant_m1 ? m1_data_i : m0_data_i;
        s_sel_o  <= grant_m1 ? m1_sel_i  : m0_sel_i;
        tmo_cnt  <= '0;
        if (grant_m1 || !m1_req_i)
          starve_cnt <= '0;
        else if (starve_cnt < 4'(STARVE_MAX))
          starve_cnt <= starve_cnt + 4'd1;
      end else if (state != IDLE && !drop) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (drop) begin
        s_cyc_o <= 1'b0;
        s_stb_o <= 1'b0;
        s_we_o  <= 1'b0;
      end
      if (done_ok) begin
        if (owner) begin
          m1_ack_o  <= 1'b1;
          m1_data_o <= s_we_o ? 32'h0 : s_data_i;
        end else begin
          m0_ack_o  <= 1'b1;
          m0_data_o <= s_we_o ? 32'h0 : s_data_i;
        end
      end
      if (done_err) begin
        if (owner) m1_err_o <= 1'b1;
        else       m0_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: table of single transactions plus
// hand-written sequences for arbitration, flush, timeout and reset.
module tb_dbus_arbiter;

  logic        clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0;
  logic        m0_req_i = 0, m0_we_i = 0, m1_req_i = 0, m1_we_i = 0;
  logic [31:0] m0_addr_i = 0, m0_data_i = 0, m1_addr_i = 0, m1_data_i = 0;
  logic [3:0]  m0_sel_i = 0, m1_sel_i = 0;
  logic [31:0] s_data_i = 0;
  logic        s_ack_i = 0;
  logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, stallreq_o;
  logic [3:0]  s_sel_o;

  int errors = 0, checks = 0;
  logic [31:0] d0_exp = 0, d1_exp = 0;

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  dbus_arbiter #(.STARVE_MAX(2), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sel);
    if (m) begin
      m1_req_i = 1; m1_we_i = we; m1_addr_i = addr; m1_data_i = data; m1_sel_i = sel;
    end else begin
      m0_req_i = 1; m0_we_i = we; m0_addr_i = addr; m0_data_i = data; m0_sel_i = sel;
    end
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.m, v.we, v.addr, v.wdata, v.sel);
    #1;
    chk("stall_on_req", stallreq_o, 1);
    tick;
    chk("grant_cyc", s_cyc_o, 1);
    chk("grant_stb", s_stb_o, 1);
    chk("grant_we", s_we_o, v.we);
    chk("grant_addr", s_addr_o, v.addr);
    chk("grant_wdata", s_data_o, v.wdata);
    chk("grant_sel", s_sel_o, v.sel);
    for (int i = 0; i < v.lat; i++) begin
      tick;
      chk("busy_hold", s_cyc_o, 1);
    end
    s_ack_i = 1; s_data_i = v.rdata;
    tick;
    s_ack_i = 0;
    chk("owner_ack", v.m ? m1_ack_o : m0_ack_o, 1);
    chk("other_ack", v.m ? m0_ack_o : m1_ack_o, 0);
    chk("owner_err", v.m ? m1_err_o : m0_err_o, 0);
    chk("owner_data", v.m ? m1_data_o : m0_data_o, v.exp_data);
    chk("other_data_held", v.m ? m0_data_o : m1_data_o, v.m ? d0_exp : d1_exp);
    chk("ack_drop_cyc", s_cyc_o, 0);
    chk("ack_stall_low", stallreq_o, 0);
    if (v.m) d1_exp = v.exp_data; else d0_exp = v.exp_data;
    if (v.m) m1_req_i = 0; else m0_req_i = 0;
    tick;
    chk("ack_one_pulse", v.m ? m1_ack_o : m0_ack_o, 0);
    tick;
  endtask

  initial begin
    int n;
    logic [31:0] exp_addr[6];
    vecs[0] = '{m:0, we:0, addr:32'h100, wdata:32'h0,        rdata:32'hDEADBEEF, sel:4'hF, lat:3, exp_data:32'hDEADBEEF};
    vecs[1] = '{m:1, we:0, addr:32'h0,   wdata:32'h0,        rdata:32'h12345678, sel:4'hF, lat:0, exp_data:32'h12345678};
    vecs[2] = '{m:0, we:1, addr:32'h200, wdata:32'h11223344, rdata:32'hFFFFFFFF, sel:4'hC, lat:1, exp_data:32'h0};
    vecs[3] = '{m:1, we:1, addr:32'h400, wdata:32'hA5A5A5A5, rdata:32'hFFFFFFFF, sel:4'h3, lat:2, exp_data:32'h0};
    vecs[4] = '{m:0, we:0, addr:32'h404, wdata:32'h0,        rdata:32'hCAFEF00D, sel:4'h1, lat:5, exp_data:32'hCAFEF00D};

    // reset state
    tick; tick;
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_sel", s_sel_o, 0);
    chk("rst_addr", s_addr_o, 0);
    chk("rst_acks", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);
    chk("rst_stall", stallreq_o, 0);
    rst_n = 1;
    tick;

    foreach (vecs[i]) run_vec(vecs[i]);

    // simultaneous requests: m0 first, m1 after m0's ack
    drive(0, 1, 32'h10, 32'h11223344, 4'b1100);
    drive(1, 0, 32'h0, 32'h0, 4'hF);
    tick;
    chk("both_owner_addr", s_addr_o, 32'h10);
    chk("both_we", s_we_o, 1);
    chk("both_sel", s_sel_o, 4'b1100);
    s_ack_i = 1;
    tick;
    s_ack_i = 0;
    chk("both_m0_ack", m0_ack_o, 1);
    chk("both_m1_noack", m1_ack_o, 0);
    chk("both_stall_m1", stallreq_o, 1);
    d0_exp = 0;
    m0_req_i = 0;
    tick;
    chk("both_gap_cyc", s_cyc_o, 0);
    tick;
    chk("both_m1_cyc", s_cyc_o, 1);
    chk("both_m1_addr", s_addr_o, 32'h0);
    chk("both_m1_we", s_we_o, 0);
    s_ack_i = 1; s_data_i = 32'h55;
    tick;
    s_ack_i = 0;
    chk("both_m1_ack", m1_ack_o, 1);
    chk("both_m1_data", m1_data_o, 32'h55);
    d1_exp = 32'h55;
    m1_req_i = 0;
    tick; tick;

    // starvation limit 2: m0, m0, m1, m0, m0, m1
    exp_addr = '{32'hA0, 32'hA0, 32'hB0, 32'hA0, 32'hA0, 32'hB0};
    drive(0, 1, 32'hA0, 32'h1, 4'hF);
    drive(1, 1, 32'hB0, 32'h2, 4'hF);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!s_cyc_o && n < 10) begin tick; n++; end
      chk("starve_wait", s_cyc_o, 1);
      chk("starve_order", s_addr_o, exp_addr[k]);
      s_ack_i = 1;
      tick;
      s_ack_i = 0;
      chk("starve_ack", {m1_ack_o, m0_ack_o}, exp_addr[k] == 32'hB0 ? 32'h2 : 32'h1);
    end
    d0_exp = 0; d1_exp = 0;
    m0_req_i = 0; m1_req_i = 0;
    tick; tick;

    // flush one cycle after grant: bus held until slave ack, no master result
    drive(0, 0, 32'h300, 32'h0, 4'hF);
    tick;
    chk("flush_grant", s_cyc_o, 1);
    flush_i = 1;
    tick;
    flush_i = 0;
    chk("drain_hold", s_cyc_o, 1);
    repeat (3) begin
      tick;
      chk("drain_hold_n", s_cyc_o, 1);
      chk("drain_noack", m0_ack_o, 0);
    end
    s_ack_i = 1; s_data_i = 32'hBADBAD00;
    tick;
    s_ack_i = 0;
    m0_req_i = 0;
    chk("drain_drop", s_cyc_o, 0);
    chk("drain_ack_err", {m0_ack_o, m0_err_o}, 0);
    chk("drain_data", m0_data_o, d0_exp);
    tick;
    chk("drain_ack_err2", {m0_ack_o, m0_err_o}, 0);

    // flush together with slave ack: flush wins
    drive(1, 0, 32'h600, 32'h0, 4'hF);
    tick;
    flush_i = 1; s_ack_i = 1; s_data_i = 32'h0BAD0BAD;
    tick;
    flush_i = 0; s_ack_i = 0; m1_req_i = 0;
    chk("flushack_drop", s_cyc_o, 0);
    chk("flushack_noack", {m1_ack_o, m1_err_o}, 0);
    chk("flushack_data", m1_data_o, d1_exp);
    tick;

    // timeout on an m1 read: bus held 8 cycles then err pulse
    drive(1, 0, 32'h500, 32'h0, 4'hF);
    tick;
    for (int i = 0; i < 7; i++) begin
      tick;
      chk("tmo_hold", s_cyc_o, 1);
    end
    tick;
    chk("tmo_drop", s_cyc_o, 0);
    chk("tmo_err", m1_err_o, 1);
    chk("tmo_noack", {m1_ack_o, m0_ack_o, m0_err_o}, 0);
    chk("tmo_data", m1_data_o, d1_exp);
    m1_req_i = 0;
    tick;
    chk("tmo_err_pulse", m1_err_o, 0);
    tick;
    run_vec('{m:0, we:0, addr:32'h800, wdata:32'h0, rdata:32'h0F0F0F0F, sel:4'hF, lat:1, exp_data:32'h0F0F0F0F});

    // reset mid-BUSY with a simultaneous slave ack
    drive(0, 1, 32'h700, 32'h77777777, 4'b1010);
    tick;
    chk("rb_grant_data", s_data_o, 32'h77777777);
    tick;
    rst_n = 0; s_ack_i = 1; s_data_i = 32'h99;
    tick;
    chk("rb_cyc", {s_cyc_o, s_stb_o, s_we_o}, 0);
    chk("rb_addr", s_addr_o, 0);
    chk("rb_data", s_data_o, 0);
    chk("rb_sel", s_sel_o, 0);
    chk("rb_acks", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);
    chk("rb_m0_data", m0_data_o, 0);
    chk("rb_m1_data", m1_data_o, 0);
    m0_req_i = 0; s_ack_i = 0;
    #1;
    chk("rb_stall", stallreq_o, 0);
    rst_n = 1;
    d0_exp = 0; d1_exp = 0;
    tick;
    chk("rb_no_pulse", {m0_ack_o, m0_err_o}, 0);
    run_vec('{m:1, we:0, addr:32'h900, wdata:32'h0, rdata:32'h13572468, sel:4'hF, lat:2, exp_data:32'h13572468});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Arbitrates one shared data-RAM/bus slave port between two masters: m0 (MEM-stage load/store port) and m1 (instruction fetch port).
- Sequences each transaction with a req/ack handshake and a variable-latency slave ack.
- Generates the pipeline stall request and handles flush and slave timeout.
- Sits between the MEM/IF stages and the external data RAM.

Parameters:
- STARVE_MAX, 4: consecutive m0 grants allowed while m1 is waiting; range 1..15.
- TIMEOUT_CYC, 64: cycles in BUSY without s_ack_i before the transaction is aborted; range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  pipeline flush (exception/branch cancel).
- m0_req_i  in  1  m0 request; held high until m0_ack_o or m0_err_o.
- m0_we_i  in  1  m0 write enable.
- m0_addr_i  in  32  m0 byte address.
- m0_data_i  in  32  m0 write data.
- m0_sel_i  in  4  m0 byte lane select; bit3 = bits[31:24].
- m0_data_o  out  32  m0 read data, valid with m0_ack_o.
- m0_ack_o  out  1  m0 completion pulse.
- m0_err_o  out  1  m0 timeout pulse.
- m1_req_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i, m1_data_o, m1_ack_o, m1_err_o: same as m0, for m1.
- s_cyc_o  out  1  slave cycle active.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  32  slave address.
- s_data_o  out  32  slave write data.
- s_sel_o  out  4  slave byte lane select.
- s_data_i  in  32  slave read data.
- s_ack_i  in  1  slave ack; sampled only while s_cyc_o = 1.
- stallreq_o  out  1  stall request to the pipeline controller.

Behaviour:
- Reset: all outputs are 0, including s_sel_o = 4'b0000. State is IDLE; starve_cnt, tmo_cnt and owner are cleared.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - If flush_i = 1, no grant is issued.
  - Otherwise, if any req is high, grant m1 when m1_req_i & (~m0_req_i | starve_cnt == STARVE_MAX). Else grant m0.
  - On a grant, latch the owner's we/addr/data/sel into the s_* registers, set s_cyc_o = s_stb_o = 1, clear tmo_cnt, go to BUSY. The slave sees the request one cycle after the grant.
- starve_cnt:
  - Increments (saturating) on an m0 grant while m1_req_i = 1.
  - Cleared on an m1 grant, and on an m0 grant while m1_req_i = 0.
- BUSY:
  - s_ack_i = 1: next cycle, owner ack_o = 1 for one cycle. Owner data_o = s_data_i for a read, 32'h0 for a write. Non-owner data_o holds its value. s_cyc_o, s_stb_o and s_we_o drop to 0. Go to IDLE.
  - Re-arbitration is possible in the cycle after the ack, so back-to-back transactions are spaced by at least one idle bus cycle.
  - flush_i = 1 without s_ack_i: go to DRAIN. Bus signals are held because a slave cycle cannot be abandoned.
  - flush_i = 1 with s_ack_i in the same cycle: the flush wins. No master ack is given, and the state goes to IDLE.
  - tmo_cnt reaches TIMEOUT_CYC-1 without an ack: drop the bus, pulse owner err_o for one cycle, go to IDLE.
- DRAIN:
  - Wait for s_ack_i, or timeout, then drop the bus and go to IDLE. No ack_o or err_o is issued and data_o is unchanged.
  - flush_i is ignored.
- stallreq_o = (m0_req_i & ~m0_ack_o & ~m0_err_o) | (m1_req_i & ~m1_ack_o & ~m1_err_o). This is combinational from registered acks and the req inputs.
- ack_o and err_o are never high together and never go to the non-owner.
- Reset asserted in any state, including mid-BUSY, returns everything to the reset values on the next edge. No ack or err is issued.

Test Plan:
- Single m0 read at 0x100, slave acks 3 cycles after s_stb_o with 0xDEADBEEF -> m0_ack_o is one pulse with m0_data_o = 0xDEADBEEF; stallreq_o is 1 from req until the ack cycle, then 0.
- m0 and m1 request in the same cycle (m0 write 0x11223344 sel 4'b1100, m1 read 0x0) -> m0 is served first with s_we_o = 1 and s_sel_o = 4'b1100; m1 is granted in the cycle after m0_ack_o.
- STARVE_MAX = 2, m0 requests continuously, m1 held high -> grant order m0, m0, m1, m0, m0, m1.
- flush_i pulsed 1 cycle after the m0 grant, ack 4 cycles later -> s_cyc_o is held until the ack; m0_ack_o and m0_err_o stay 0; state returns to IDLE.
- TIMEOUT_CYC = 8, slave never acks an m1 read -> s_cyc_o drops after 8 BUSY cycles; m1_err_o is one pulse; a subsequent m0 request is granted normally.
- rst_n low for 1 cycle mid-BUSY -> all outputs are 0 on the next edge; no ack or err pulse; new requests are served after release.
